// File: rtl/player_mover_pkg.sv
// Shared constants for the player mover: directions, screen size
// and the per-axis auto-repeat state codes.
package player_mover_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

endpackage

// File: rtl/player_mover_if.sv
// Key inputs and sprite outputs between the board, the mover
// and the frame renderer.
interface player_mover_if;
  import player_mover_pkg::*;

  logic       game_state;
  logic       keyUp;
  logic       keyDown;
  logic       keyLeft;
  logic       keyRight;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [9:0] player_size;
  logic       moved;
  logic       blocked;
  logic [1:0] last_dir;

  modport master (
    output game_state, keyUp, keyDown,
    output keyLeft, keyRight,
    input  player_x, player_y, player_size,
    input  moved, blocked, last_dir
  );

  modport slave (
    input  game_state, keyUp, keyDown,
    input  keyLeft, keyRight,
    output player_x, player_y, player_size,
    output moved, blocked, last_dir
  );
endinterface

// File: rtl/player_mover_axis_repeater.sv
// One movement axis: key synchronisers plus a press/first-delay/
// repeat FSM that emits single-cycle step pulses.
module axis_repeater
  import player_mover_pkg::*;
#(
  parameter int FIRST_DELAY  = 12_000_000,
  parameter int REPEAT_DELAY = 4_000_000,
  parameter int CNT_W        = 32
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic neg_n,
  input  logic pos_n,
  output logic step_neg,
  output logic step_pos
);

  localparam logic [CNT_W-1:0] L_FIRST =
    CNT_W'(FIRST_DELAY - 1);
  localparam logic [CNT_W-1:0] L_REP =
    CNT_W'(REPEAT_DELAY - 1);

  logic             r_neg_s1, r_neg_s2;
  logic             r_pos_s1, r_pos_s2;
  logic [1:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_lim;
  logic             r_dir, w_dir_nx;
  logic             w_neg, w_pos, w_press, w_step;

  // game_state must not disturb the synchronisers
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_neg_s1 <= 1'b1;
      r_neg_s2 <= 1'b1;
      r_pos_s1 <= 1'b1;
      r_pos_s2 <= 1'b1;
    end else begin
      r_neg_s1 <= neg_n;
      r_neg_s2 <= r_neg_s1;
      r_pos_s1 <= pos_n;
      r_pos_s2 <= r_pos_s1;
    end
  end

  assign w_neg   = ~r_neg_s2;
  assign w_pos   = ~r_pos_s2;
  assign w_press = w_neg ^ w_pos;
  assign w_lim   = (r_state == ST_FIRST) ? L_FIRST : L_REP;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir;
    w_step     = 1'b0;
    if (!w_press) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else if (r_state == ST_IDLE) begin
      w_step     = 1'b1;
      w_state_nx = ST_FIRST;
      w_cnt_nx   = '0;
      w_dir_nx   = w_pos;
    end else if (w_pos != r_dir) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else if (r_cnt == w_lim) begin
      w_step     = 1'b1;
      w_state_nx = ST_REPEAT;
      w_cnt_nx   = '0;
    end else begin
      w_cnt_nx   = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
    end
  end

  assign step_neg = w_step & ~clear & ~w_pos;
  assign step_pos = w_step & ~clear & w_pos;

endmodule

// File: rtl/player_mover.sv
// Grid-stepped player position with per-axis auto-repeat and
// bounds checking inside a configurable rectangle.
module player_mover
  import player_mover_pkg::*;
#(
  parameter int STEP         = 16,
  parameter int SIZE         = 16,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 624,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 464,
  parameter int X_START      = 320,
  parameter int Y_START      = 224,
  parameter int FIRST_DELAY  = 12_000_000,
  parameter int REPEAT_DELAY = 4_000_000,
  parameter int CNT_W        = 32
) (
  input logic           CLOCK_50,
  input logic           reset,
  player_mover_if.slave bus
);

  localparam logic [10:0] L_STEP = 11'(STEP);
  localparam logic [10:0] L_XMIN = 11'(X_MIN);
  localparam logic [10:0] L_XMAX = 11'(X_MAX);
  localparam logic [10:0] L_YMIN = 11'(Y_MIN);
  localparam logic [10:0] L_YMAX = 11'(Y_MAX);

  logic       w_clear;
  logic       w_l, w_r, w_u, w_d;
  logic [10:0] w_x, w_y;
  logic       w_xok_n, w_xok_p, w_yok_n, w_yok_p;
  logic       w_xapp, w_yapp, w_xref, w_yref;
  logic [9:0] r_x, r_y;
  logic       r_moved, r_blocked;
  logic [1:0] r_dir;

  assign w_clear = ~reset | bus.game_state;

  axis_repeater #(
    .FIRST_DELAY (FIRST_DELAY),
    .REPEAT_DELAY(REPEAT_DELAY),
    .CNT_W       (CNT_W)
  ) u_x (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (w_clear),
    .neg_n   (bus.keyLeft),
    .pos_n   (bus.keyRight),
    .step_neg(w_l),
    .step_pos(w_r)
  );

  axis_repeater #(
    .FIRST_DELAY (FIRST_DELAY),
    .REPEAT_DELAY(REPEAT_DELAY),
    .CNT_W       (CNT_W)
  ) u_y (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (w_clear),
    .neg_n   (bus.keyUp),
    .pos_n   (bus.keyDown),
    .step_neg(w_u),
    .step_pos(w_d)
  );

  // 11-bit compare so a step below zero never wraps
  assign w_x     = {1'b0, r_x};
  assign w_y     = {1'b0, r_y};
  assign w_xok_n = w_x >= L_XMIN + L_STEP;
  assign w_xok_p = w_x + L_STEP <= L_XMAX;
  assign w_yok_n = w_y >= L_YMIN + L_STEP;
  assign w_yok_p = w_y + L_STEP <= L_YMAX;

  assign w_xapp = (w_l & w_xok_n) | (w_r & w_xok_p);
  assign w_xref = (w_l & ~w_xok_n) | (w_r & ~w_xok_p);
  assign w_yapp = (w_u & w_yok_n) | (w_d & w_yok_p);
  assign w_yref = (w_u & ~w_yok_n) | (w_d & ~w_yok_p);

  always_ff @(posedge CLOCK_50) begin
    if (w_clear) begin
      r_x       <= 10'(X_START);
      r_y       <= 10'(Y_START);
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      r_dir     <= DIR_UP;
    end else begin
      r_moved   <= w_xapp | w_yapp;
      r_blocked <= w_xref | w_yref;
      if (w_xapp)
        r_x <= w_r ? r_x + 10'(STEP) : r_x - 10'(STEP);
      if (w_yapp)
        r_y <= w_d ? r_y + 10'(STEP) : r_y - 10'(STEP);
      if (w_xapp)
        r_dir <= w_r ? DIR_RIGHT : DIR_LEFT;
      else if (w_yapp)
        r_dir <= w_d ? DIR_DOWN : DIR_UP;
    end
  end

  assign bus.player_x    = r_x;
  assign bus.player_y    = r_y;
  assign bus.player_size = 10'(SIZE);
  assign bus.moved       = r_moved;
  assign bus.blocked     = r_blocked;
  assign bus.last_dir    = r_dir;

endmodule

// File: tb/tb_player_mover.sv
// Directed checks of player_mover with short delays.
module tb_player_mover;
  import player_mover_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_mv   = 0;
  int   n_bl   = 0;
  int   cyc    = 0;
  int   x_max  = 0;
  int   t0;
  int   q_mv[$];

  player_mover_if bus ();

  player_mover #(
    .FIRST_DELAY (10),
    .REPEAT_DELAY(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (bus.moved) begin
      n_mv++;
      q_mv.push_back(cyc);
    end
    if (bus.blocked) n_bl++;
    if (int'(bus.player_x) > x_max)
      x_max = int'(bus.player_x);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d",
                  tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic clr();
    n_mv = 0;
    n_bl = 0;
    q_mv.delete();
  endtask

  initial begin
    reset          = 1'b0;
    bus.game_state = 1'b0;
    bus.keyUp      = 1'b0;
    bus.keyDown    = 1'b0;
    bus.keyLeft    = 1'b0;
    bus.keyRight   = 1'b0;
    tick(3);
    chk("rst_x", 32'(bus.player_x), 32'd320);
    chk("rst_y", 32'(bus.player_y), 32'd224);
    chk("rst_mv", 32'(bus.moved), 32'd0);
    chk("rst_bl", 32'(bus.blocked), 32'd0);
    chk("rst_dir", 32'(bus.last_dir), 32'd0);
    chk("size", 32'(bus.player_size), 32'd16);
    bus.keyUp    = 1'b1;
    bus.keyDown  = 1'b1;
    bus.keyLeft  = 1'b1;
    bus.keyRight = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(4);
    chk("idle_x", 32'(bus.player_x), 32'd320);

    // tap right
    clr();
    bus.keyRight = 1'b0;
    tick(1);
    bus.keyRight = 1'b1;
    chk("tap_mv_n", 32'(bus.moved), 32'd0);
    tick(1);
    chk("tap_mv_n1", 32'(bus.moved), 32'd0);
    tick(1);
    chk("tap_mv_n2", 32'(bus.moved), 32'd1);
    chk("tap_x", 32'(bus.player_x), 32'd336);
    chk("tap_dir", 32'(bus.last_dir), 32'd3);
    tick(20);
    chk("tap_cnt", 32'(n_mv), 32'd1);

    // hold down 30 cycles
    clr();
    t0 = cyc;
    bus.keyDown = 1'b0;
    tick(30);
    bus.keyDown = 1'b1;
    tick(10);
    chk("hold_cnt", 32'(n_mv), 32'd6);
    chk("hold_y", 32'(bus.player_y), 32'd320);
    chk("hold_dir", 32'(bus.last_dir), 32'd1);
    if (q_mv.size() == 6) begin
      chk("hold_lat", 32'(q_mv[0] - t0), 32'd3);
      chk("hold_g1", 32'(q_mv[1] - q_mv[0]), 32'd10);
      for (int i = 2; i < 6; i++)
        chk("hold_gr", 32'(q_mv[i] - q_mv[i-1]), 32'd4);
    end else begin
      chk("hold_q", 32'(q_mv.size()), 32'd6);
    end

    // right bound
    clr();
    bus.keyRight = 1'b0;
    tick(100);
    bus.keyRight = 1'b1;
    tick(6);
    chk("rb_x", 32'(bus.player_x), 32'd624);
    chk("rb_mv", 32'(n_mv), 32'd18);
    chk("rb_bl", 32'(n_bl), 32'd6);
    chk("rb_dir", 32'(bus.last_dir), 32'd3);

    // left bound
    clr();
    bus.keyLeft = 1'b0;
    tick(200);
    bus.keyLeft = 1'b1;
    tick(6);
    chk("lb_x", 32'(bus.player_x), 32'd0);
    chk("lb_mv", 32'(n_mv), 32'd39);
    chk("lb_bl", 32'(n_bl), 32'd10);
    chk("lb_dir", 32'(bus.last_dir), 32'd2);
    chk("x_max", 32'(x_max), 32'd624);

    // conflicting horizontal keys
    clr();
    bus.keyLeft  = 1'b0;
    bus.keyRight = 1'b0;
    tick(20);
    bus.keyLeft  = 1'b1;
    bus.keyRight = 1'b1;
    tick(5);
    chk("cf_mv", 32'(n_mv), 32'd0);
    chk("cf_bl", 32'(n_bl), 32'd0);
    chk("cf_x", 32'(bus.player_x), 32'd0);

    // diagonal up-right
    clr();
    bus.keyUp    = 1'b0;
    bus.keyRight = 1'b0;
    tick(1);
    bus.keyUp    = 1'b1;
    bus.keyRight = 1'b1;
    tick(2);
    chk("dg_x", 32'(bus.player_x), 32'd16);
    chk("dg_y", 32'(bus.player_y), 32'd304);
    chk("dg_pulse", 32'(bus.moved), 32'd1);
    chk("dg_dir", 32'(bus.last_dir), 32'd3);
    tick(15);
    chk("dg_cnt", 32'(n_mv), 32'd1);

    // abort during repeat, then restart
    bus.keyRight = 1'b0;
    tick(18);
    bus.game_state = 1'b1;
    tick(1);
    chk("ab_x", 32'(bus.player_x), 32'd320);
    chk("ab_y", 32'(bus.player_y), 32'd224);
    chk("ab_mv", 32'(bus.moved), 32'd0);
    chk("ab_dir", 32'(bus.last_dir), 32'd0);
    bus.game_state = 1'b0;
    tick(1);
    chk("rs_x0", 32'(bus.player_x), 32'd336);
    tick(9);
    chk("rs_x9", 32'(bus.player_x), 32'd336);
    tick(1);
    chk("rs_x10", 32'(bus.player_x), 32'd352);
    bus.keyRight = 1'b1;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
